dcache_weights_refill: RTL and testbench
========================================

// Module: dcache_weights_refill
// PURPOSE
//  Parametrised, read-only, direct-mapped weight cache between the compute datapath and backing weight memory.
//  Generalises the fixed 64-bit weight read path: configurable data width, line size and depth.
//  Adds a ready/valid request handshake, multi-beat line refill from memory on a miss, and a whole-cache flush.
// PARAMETERS
//  ADDR_WIDTH  32  byte address width
//  DATA_WIDTH  64  word width in bits; power of 2, >= 8
//  LINE_WORDS  4   words per cache line; power of 2, >= 2
//  NUM_LINES   16  number of lines; power of 2, >= 2
// PORTS
//  CLK        in   1           clock; all state changes on posedge
//  RST        in   1           reset, asynchronous, active-high
//  address    in   ADDR_WIDTH  byte address of the requested word; low log2(DATA_WIDTH/8) bits ignored
//  read       in   1           request strobe; accepted when read && ready at posedge CLK
//  ready      out  1           cache can accept a request this cycle
//  data_out   out  DATA_WIDTH  requested word; meaningful only while valid = 1
//  valid      out  1           one-cycle response pulse per accepted request
//  flush      in   1           invalidate all lines
//  mem_req    out  1           line refill request to backing memory
//  mem_addr   out  ADDR_WIDTH  line-aligned byte address of the refill
//  mem_data   in   DATA_WIDTH  refill beat data
//  mem_valid  in   1           refill beat strobe; beats arrive in ascending word order
// BEHAVIOUR
//  Address fields, lowest to highest:
//   - byte offset: log2(DATA_WIDTH/8) bits
//   - word offset: log2(LINE_WORDS) bits
//   - index: log2(NUM_LINES) bits
//   - tag: all remaining bits
//  Reset values:
//   - all line valid bits = 0; state = IDLE
//   - data_out = 0, valid = 0, mem_req = 0, mem_addr = 0, beat counter = 0, pending flush = 0
//  Handshake:
//   - ready = (state == IDLE) && !flush
//   - read while ready = 0 is ignored; nothing is queued
//  FSM IDLE:
//   - Accepted hit: next cycle valid = 1 and data_out = the requested word. State stays IDLE.
//   - Throughput is one hit per cycle.
//   - Accepted miss: latch the address. Go to REFILL. mem_addr = line base. mem_req = 1 from the next cycle.
//  FSM REFILL:
//   - mem_req stays high until the first mem_valid, then drops.
//   - Each mem_valid writes mem_data to word [beat] of the indexed line, then beat++.
//   - On the beat with beat == LINE_WORDS-1: write tag, set the line valid, clear beat, go to RESPOND.
//  FSM RESPOND:
//   - Lasts one cycle: valid = 1, data_out = the requested word from the refilled line. Then IDLE.
//   - Miss latency = memory latency + LINE_WORDS beats + 1 cycle.
//  valid is 0 in every cycle not listed above. data_out holds its last value while valid = 0.
//  Flush:
//   - In IDLE: all valid bits clear at that posedge. A read asserted in the same cycle is not accepted.
//   - During REFILL/RESPOND: latched as pending. The refill and its response complete normally.
//   - Pending flush clears all valid bits on the first IDLE cycle; ready = 0 in that cycle.
//  mem_valid outside REFILL is ignored, including stray beats after a reset mid-refill.
//  Reset asserted mid-refill aborts immediately. The partially written line stays invalid. No response is issued.
//  Conflict miss on a valid line overwrites it; there is no write-back (read-only cache).
//  Full-width tag compare: addresses at the top of the space alias nothing.
// CONFIGURATION
//  DCACHE_WEIGHTS_STATS_EN defined:
//   - Adds outputs hit_count [31:0] and miss_count [31:0].
//   - Each counter increments once per accepted hit/miss, wraps at 2^32, and resets to 0.
//   - Flush does not clear them.
//  Not defined: the ports and counters do not exist; all other behaviour is identical.
// TESTING
//  (defaults; line = 32 B, cache span = 512 B; memory model returns beats 2 cycles after mem_req, data = byte address)
//  1. Reset, then read @0x6200 -> mem_req, mem_addr=0x6200; 4 beats; valid=1 data_out=0x6200; ready high next cycle.
//  2. Then reads @0x6208, 0x6218 back-to-back -> valid on consecutive cycles, data 0x6208/0x6218; no mem_req.
//  3. Read @0x6400 (same index as 0x6200) -> refill at 0x6400; a following read @0x6200 misses again.
//  4. read=0 with address=0x6380 -> no valid, no mem_req; then read @0x63a0 -> refill at 0x63a0, data_out=0x63a0.
//  5. flush pulse during refill of 0x6380 -> response still 0x6380; the next read @0x6380 misses.
//  6. RST mid-refill, then stray mem_valid -> ignored; read @0x6200 misses; (STATS_EN) hit/miss counts match the sequence.

Source files
------------

// File: rtl/dcache_weights_refill.sv
// Read-only direct-mapped weight cache with multi-beat line refill and whole-cache flush.
// Optional hit/miss counters are built when DCACHE_WEIGHTS_STATS_EN is defined.
module dcache_weights_refill #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  read,
  output logic                  ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid,
  input  logic                  flush,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  mem_valid
`ifdef DCACHE_WEIGHTS_STATS_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);

  localparam int OFF_W   = $clog2(DATA_WIDTH / 8);
  localparam int WO_W    = $clog2(LINE_WORDS);
  localparam int IDX_W   = $clog2(NUM_LINES);
  localparam int LINE_SH = OFF_W + WO_W;
  localparam int TAG_W   = ADDR_WIDTH - LINE_SH - IDX_W;
  localparam int REQ_W   = ADDR_WIDTH - OFF_W;
  localparam logic [WO_W-1:0] LAST_BEAT = WO_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REFILL,
    S_RESPOND
  } state_e;

  logic [DATA_WIDTH-1:0] data_mem [NUM_LINES*LINE_WORDS];
  logic [TAG_W-1:0]      tag_mem  [NUM_LINES];

  state_e                state_q, state_d;
  logic [NUM_LINES-1:0]  lvalid_q, lvalid_d;
  logic [REQ_W-1:0]      req_q, req_d;
  logic [WO_W-1:0]       beat_q, beat_d;
  logic                  pend_q, pend_d;
  logic                  valid_q, valid_d;
  logic                  mem_req_q, mem_req_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

  logic [IDX_W-1:0] in_idx, req_idx;
  logic [WO_W-1:0]  in_wo, req_wo;
  logic [TAG_W-1:0] in_tag, req_tag;
  logic             hit, acc_hit, acc_miss, wr_en;

  assign in_idx  = address[LINE_SH +: IDX_W];
  assign in_wo   = address[OFF_W +: WO_W];
  assign in_tag  = address[ADDR_WIDTH-1 -: TAG_W];
  assign req_idx = req_q[WO_W +: IDX_W];
  assign req_wo  = req_q[WO_W-1:0];
  assign req_tag = req_q[REQ_W-1 -: TAG_W];

  assign hit   = lvalid_q[in_idx] && (tag_mem[in_idx] == in_tag);
  assign wr_en = (state_q == S_REFILL) && mem_valid;

  always_comb begin
    state_d    = state_q;
    lvalid_d   = lvalid_q;
    req_d      = req_q;
    beat_d     = beat_q;
    pend_d     = pend_q;
    valid_d    = 1'b0;
    mem_req_d  = mem_req_q;
    data_out_d = data_out_q;
    ready      = 1'b0;
    acc_hit    = 1'b0;
    acc_miss   = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready = !flush && !pend_q;
        if (flush || pend_q) begin
          lvalid_d = '0;
          pend_d   = 1'b0;
        end else if (read) begin
          if (hit) begin
            acc_hit    = 1'b1;
            valid_d    = 1'b1;
            data_out_d = data_mem[{in_idx, in_wo}];
          end else begin
            // Line is invalidated up front so an aborted refill never leaves stale data visible.
            acc_miss         = 1'b1;
            req_d            = address[ADDR_WIDTH-1:OFF_W];
            mem_req_d        = 1'b1;
            beat_d           = '0;
            lvalid_d[in_idx] = 1'b0;
            state_d          = S_REFILL;
          end
        end
      end
      S_REFILL: begin
        if (flush) pend_d = 1'b1;
        if (mem_valid) begin
          mem_req_d = 1'b0;
          beat_d    = beat_q + WO_W'(1);
          if (beat_q == LAST_BEAT) begin
            lvalid_d[req_idx] = 1'b1;
            beat_d            = '0;
            valid_d           = 1'b1;
            state_d           = S_RESPOND;
            // The last beat is still in flight to the array, so forward it directly.
            data_out_d = (req_wo == LAST_BEAT) ? mem_data : data_mem[{req_idx, req_wo}];
          end
        end
      end
      S_RESPOND: begin
        if (flush) pend_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      lvalid_q   <= '0;
      req_q      <= '0;
      beat_q     <= '0;
      pend_q     <= 1'b0;
      valid_q    <= 1'b0;
      mem_req_q  <= 1'b0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      lvalid_q   <= lvalid_d;
      req_q      <= req_d;
      beat_q     <= beat_d;
      pend_q     <= pend_d;
      valid_q    <= valid_d;
      mem_req_q  <= mem_req_d;
      data_out_q <= data_out_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      data_mem[{req_idx, beat_q}] <= mem_data;
      if (beat_q == LAST_BEAT) tag_mem[req_idx] <= req_tag;
    end
  end

`ifdef DCACHE_WEIGHTS_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (acc_hit)  hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (acc_miss) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

  assign valid    = valid_q;
  assign data_out = data_out_q;
  assign mem_req  = mem_req_q;
  assign mem_addr = {req_q[REQ_W-1:WO_W], {LINE_SH{1'b0}}};

endmodule

// File: tb/tb_dcache_weights_refill.sv
// Randomised bench for dcache_weights_refill against a line-level cache model and a
// backing memory whose data equals the byte address.
module tb_dcache_weights_refill;

  localparam int AW      = 32;
  localparam int DW      = 64;
  localparam int LW      = 4;
  localparam int NL      = 16;
  localparam int MEM_LAT = 2;
  localparam int WORD_B  = DW / 8;
  localparam int LINE_B  = WORD_B * LW;

  logic          CLK = 1'b0;
  logic          RST;
  logic [AW-1:0] address;
  logic          read;
  logic          ready;
  logic [DW-1:0] data_out;
  logic          valid;
  logic          flush;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_valid;
`ifdef DCACHE_WEIGHTS_STATS_EN
  logic [31:0]   hit_count;
  logic [31:0]   miss_count;
`endif

  dcache_weights_refill #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WORDS(LW), .NUM_LINES(NL)
  ) dut (
    .CLK(CLK), .RST(RST), .address(address), .read(read), .ready(ready),
    .data_out(data_out), .valid(valid), .flush(flush), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_valid(mem_valid)
`ifdef DCACHE_WEIGHTS_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model: which memory line each index currently holds.
  bit              ref_v [NL];
  longint unsigned ref_line [NL];
  int              ref_hits;
  int              ref_misses;

  function automatic bit ref_hit(input logic [AW-1:0] a);
    longint unsigned ln;
    ln = longint'(a) / LINE_B;
    return ref_v[ln % NL] && (ref_line[ln % NL] == ln);
  endfunction

  task automatic ref_clear();
    for (int i = 0; i < NL; i++) ref_v[i] = 1'b0;
  endtask

  // Backing memory: first beat MEM_LAT cycles after mem_req is seen, then LW consecutive beats.
  initial begin
    logic [AW-1:0] base;
    mem_valid = 1'b0;
    mem_data  = '0;
    forever begin
      @(posedge CLK); #1;
      if (mem_req) begin
        base = mem_addr;
        repeat (MEM_LAT) @(posedge CLK);
        #1;
        for (int i = 0; i < LW; i++) begin
          mem_valid = 1'b1;
          mem_data  = DW'(base + AW'(i * WORD_B));
          @(posedge CLK); #1;
        end
        mem_valid = 1'b0;
      end
    end
  end

  // One read transaction, entered and left 1 time unit after a posedge.
  task automatic do_read(input logic [AW-1:0] a, input bit flush_mid);
    bit              exp_hit;
    int              n;
    longint unsigned ln;
    logic [AW-1:0]   exp_word;
    exp_hit  = ref_hit(a);
    ln       = longint'(a) / LINE_B;
    exp_word = a & ~AW'(WORD_B - 1);
    check("ready_before_read", ready, 1'b1);
    address = a;
    read    = 1'b1;
    @(posedge CLK); #1;
    read    = 1'b0;
    address = $urandom;
    @(negedge CLK);
    if (exp_hit) begin
      ref_hits++;
      check("hit_valid", valid, 1'b1);
      check("hit_data", data_out, DW'(exp_word));
      check("hit_no_mem_req", mem_req, 1'b0);
      $display("read 0x%08h hit  data 0x%0h", a, data_out);
      @(posedge CLK); #1;
    end else begin
      ref_misses++;
      check("miss_no_early_valid", valid, 1'b0);
      check("miss_mem_req", mem_req, 1'b1);
      check("miss_mem_addr", mem_addr, a & ~AW'(LINE_B - 1));
      n = 0;
      for (int c = 1; c <= 50; c++) begin
        @(posedge CLK); #1;
        flush = flush_mid && (c == 2);
        n = c;
        @(negedge CLK);
        if (valid) break;
      end
      flush = 1'b0;
      check("miss_valid", valid, 1'b1);
      check("miss_latency", n + 1, MEM_LAT + LW + 1);
      check("miss_data", data_out, DW'(exp_word));
      check("miss_req_dropped", mem_req, 1'b0);
      $display("read 0x%08h miss data 0x%0h latency %0d flush_mid %0d", a, data_out, n + 1, flush_mid);
      ref_v[ln % NL]    = 1'b1;
      ref_line[ln % NL] = ln;
      @(posedge CLK); #1;
      if (flush_mid) begin
        check("pending_flush_ready", ready, 1'b0);
        ref_clear();
        @(posedge CLK); #1;
      end
    end
  endtask

  task automatic do_hits2(input logic [AW-1:0] a, input logic [AW-1:0] b);
    address = a;
    read    = 1'b1;
    @(posedge CLK); #1;
    address = b;
    @(negedge CLK);
    check("b2b_valid_a", valid, 1'b1);
    check("b2b_data_a", data_out, DW'(a & ~AW'(WORD_B - 1)));
    @(posedge CLK); #1;
    read = 1'b0;
    @(negedge CLK);
    check("b2b_valid_b", valid, 1'b1);
    check("b2b_data_b", data_out, DW'(b & ~AW'(WORD_B - 1)));
    check("b2b_no_mem_req", mem_req, 1'b0);
    ref_hits += 2;
    $display("back-to-back hits 0x%08h 0x%08h", a, b);
    @(posedge CLK); #1;
  endtask

  task automatic flush_idle(input logic [AW-1:0] a);
    address = a;
    read    = 1'b1;
    flush   = 1'b1;
    #1;
    check("flush_ready_low", ready, 1'b0);
    @(posedge CLK); #1;
    read  = 1'b0;
    flush = 1'b0;
    @(negedge CLK);
    check("flush_read_ignored_valid", valid, 1'b0);
    check("flush_read_ignored_req", mem_req, 1'b0);
    ref_clear();
    $display("flush in idle with read 0x%08h", a);
    @(posedge CLK); #1;
  endtask

  task automatic idle_read_low(input logic [AW-1:0] a, input int cycles);
    address = a;
    read    = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge CLK);
      check("idle_no_valid", valid, 1'b0);
      check("idle_no_req", mem_req, 1'b0);
      @(posedge CLK); #1;
    end
    $display("read=0 at 0x%08h for %0d cycles", a, cycles);
  endtask

  task automatic check_stats();
`ifdef DCACHE_WEIGHTS_STATS_EN
    check("hit_count", hit_count, 64'(ref_hits));
    check("miss_count", miss_count, 64'(ref_misses));
`endif
  endtask

  initial begin
    logic [AW-1:0] regions [4];
    logic [AW-1:0] a;
    regions[0] = 32'h0000_6000;
    regions[1] = 32'h0000_6200;
    regions[2] = 32'hFFFF_FE00;
    regions[3] = 32'h0000_0000;
    ref_clear();
    ref_hits   = 0;
    ref_misses = 0;
    RST     = 1'b1;
    read    = 1'b0;
    flush   = 1'b0;
    address = '0;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    check("rst_valid", valid, 1'b0);
    check("rst_data_out", data_out, '0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_addr", mem_addr, '0);
    check("rst_ready", ready, 1'b1);
    @(posedge CLK); #1;

    do_read(32'h6200, 1'b0);
    do_hits2(32'h6208, 32'h6218);
    do_read(32'h6400, 1'b0);
    do_read(32'h6200, 1'b0);
    idle_read_low(32'h6380, 3);
    do_read(32'h63a0, 1'b0);
    do_read(32'h6380, 1'b1);
    do_read(32'h6380, 1'b0);
    flush_idle(32'h6380);
    do_read(32'h6384, 1'b0);
    do_read(32'hFFFF_FFFC, 1'b0);
    do_read(32'h0000_01E0, 1'b0);
    do_read(32'hFFFF_FFF8, 1'b0);
    check_stats();

    for (int t = 0; t < 60; t++) begin
      a = regions[$urandom_range(0, 3)] + AW'($urandom_range(0, 511));
      if ($urandom_range(0, 9) == 0) flush_idle(a);
      if ($urandom_range(0, 3) == 0) idle_read_low($urandom, $urandom_range(1, 2));
      do_read(a, $urandom_range(0, 5) == 0);
    end
    check_stats();

    // Reset during a refill; the memory model keeps delivering the rest as stray beats.
    address = 32'h6200;
    read    = 1'b1;
    if (!ref_hit(32'h6200)) ref_misses++;
    @(posedge CLK); #1;
    read = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    RST = 1'b1;
    #2;
    check("midrst_mem_req", mem_req, 1'b0);
    check("midrst_valid", valid, 1'b0);
    @(posedge CLK); #1;
    RST = 1'b0;
    ref_clear();
    ref_hits   = 0;
    ref_misses = 0;
    $display("reset asserted mid-refill");
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      check("stray_no_valid", valid, 1'b0);
      check("stray_no_req", mem_req, 1'b0);
      @(posedge CLK); #1;
    end
    check_stats();
    do_read(32'h6200, 1'b0);
    do_read(32'h6210, 1'b0);
    check_stats();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
